sram_mix_scheduler: RTL and testbench
=====================================

SRAM_MIX_SCHEDULER -- requirements
Module: sram_mix_scheduler

Interface
REQ-001 Parameter NUM_TRACK, default 4: number of playback tracks stored in SRAM.
REQ-002 Parameter TRACK_BASE, default 20'h20000: SRAM address of track 0, sample 0.
REQ-003 Parameter TRACK_STRIDE, default 20'h20000: address distance between consecutive track bases.
REQ-004 Parameter TRACK_LEN, default 20'h20000: samples per track, about 4 s.
REQ-005 i_clk  in  1  system clock; the only clock, all state on its rising edge.
REQ-006 i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_start  in  1  one-cycle pulse; begins playback at offset 0.
REQ-008 i_stop  in  1  one-cycle pulse; requests return to IDLE.
REQ-009 i_loop  in  1  1 = wrap and continue at end of track; 0 = stop at end.
REQ-010 i_track_en  in  NUM_TRACK  per-track mix enable, sampled at each frame start.
REQ-011 i_daclrck  in  1  codec DAC LR clock, asynchronous to i_clk.
REQ-012 i_wr_req / i_wr_addr / i_wr_data  in  1/20/16  recorder write request, level-held until ack.
REQ-013 o_wr_ack  out  1  one-cycle pulse in the cycle the write is driven.
REQ-014 o_sram_addr / o_sram_we_n / o_sram_wdata / o_sram_dq_oe  out  20/1/16/1  SRAM address, write strobe (0 = write), write data, DQ drive enable.
REQ-015 i_sram_rdata  in  16  SRAM read data, valid one cycle after the address.
REQ-016 o_mix_data / o_mix_valid  out  16/1  signed mixed sample, one-cycle valid pulse per frame.
REQ-017 o_offset / o_busy / o_done  out  20/1/1  current sample offset; asserted outside IDLE; one-cycle end-of-track pulse.

Function
REQ-018 i_daclrck SHALL pass through a 2-flop synchronizer; a frame event SHALL be a 0->1 transition of the synchronized signal.
REQ-019 FSM states SHALL be IDLE, WAIT_FRAME, WRITE, READ, SAT.
- IDLE -> WAIT_FRAME on i_start.
- WAIT_FRAME -> READ on a frame event.
- WAIT_FRAME -> WRITE on i_wr_req when no frame event is present.
- WRITE -> WAIT_FRAME after 1 cycle.
- READ -> SAT after NUM_TRACK+1 cycles.
- SAT -> WAIT_FRAME or IDLE (REQ-026, REQ-027).
REQ-020 The READ state SHALL use read cycle k (k = 0..NUM_TRACK-1) to drive o_sram_addr = TRACK_BASE + k*TRACK_STRIDE + o_offset with we_n=1, dq_oe=0. In cycle k+1 it SHALL capture i_sram_rdata for track k.
REQ-021 A captured sample SHALL be added sign-extended into an 18-bit accumulator if its i_track_en bit (latched at the frame event) is 1; otherwise it SHALL add 0. The cycle count is the same regardless of the enables.
REQ-022 The SAT state SHALL clamp the accumulator to [-32768, 32767], register the result on o_mix_data, and pulse o_mix_valid. o_mix_valid therefore rises NUM_TRACK+2 cycles after the frame-event cycle.
REQ-023 The WRITE state SHALL drive o_sram_addr=i_wr_addr, o_sram_wdata=i_wr_data, we_n=0, dq_oe=1 and o_wr_ack=1 for exactly one cycle. we_n SHALL be 1 in every other cycle.
REQ-024 A frame event SHALL take priority over i_wr_req in the same cycle; the write waits until the frame completes.
REQ-025 A frame event arriving during WRITE, READ or SAT SHALL be latched in a pending flag and serviced on the next WAIT_FRAME cycle. Only one pending event is held; further events are dropped.
REQ-026 In SAT, o_offset SHALL increment. At TRACK_LEN-1 it SHALL wrap to 0 and pulse o_done. If i_loop=0 at that moment, the next state SHALL be IDLE.
REQ-027 i_stop in IDLE or WAIT_FRAME SHALL give IDLE on the next cycle.
- i_stop during WRITE/READ/SAT SHALL be latched. The current write or frame completes, including o_mix_valid, then the FSM goes to IDLE.
- Entering IDLE SHALL clear o_offset to 0.
REQ-028 i_start outside IDLE SHALL be ignored; i_start and i_stop together in IDLE SHALL leave the block in IDLE.
REQ-029 o_mix_data SHALL hold its value between valid pulses.

Reset
REQ-030 Asserting i_rst_n low at any time, including mid-frame or mid-write, SHALL immediately set:
- state=IDLE;
- o_sram_addr=0, o_sram_we_n=1, o_sram_dq_oe=0, o_sram_wdata=0;
- o_mix_data=0, o_mix_valid=0, o_wr_ack=0, o_offset=0, o_busy=0, o_done=0;
- accumulator, pending flags and synchronizer cleared.

Verification
REQ-031 Track 0 sample 0 = 16'h1000, track 1 sample 0 = 16'h0200, enables 4'b0011, start, one LRCK rise -> addresses 20'h20000, 20'h40000, 20'h60000, 20'h80000 issued; o_mix_data=16'h1200 with valid at frame-event +6; o_offset=1.
REQ-032 All four tracks 16'h7000, enables 4'b1111 -> o_mix_data=16'h7FFF. All four 16'h8000 -> o_mix_data=16'h8000.
REQ-033 i_wr_req held with addr 20'h00010, data 16'hABCD, rising in the same cycle as the frame event -> frame runs first; one we_n=0 cycle with dq_oe=1 and o_wr_ack follows SAT; no write overlaps READ.
REQ-034 TRACK_LEN overridden to 4, i_loop=0 -> o_done pulses on the 4th frame, then IDLE with o_offset=0. With i_loop=1 -> offset sequence 1,2,3,0,1 and stays busy.
REQ-035 i_stop in read cycle 2 -> o_mix_valid still pulses, then IDLE. Reset asserted mid-READ -> all outputs at reset values within the same cycle; no o_mix_valid after release until a new i_start.

Source files
------------

// File: rtl/sram_mix_scheduler_if.sv
// Signal bundle between the mix scheduler, the recorder write port, the external SRAM and the mix consumer.
// Write handshake: i_wr_req plus addr/data stay held until o_wr_ack; the ack cycle is the cycle the write is on the pins.
interface sram_mix_scheduler_if;
    logic        i_wr_req;
    logic [19:0] i_wr_addr;
    logic [15:0] i_wr_data;
    logic        o_wr_ack;
    logic [19:0] o_sram_addr;
    logic        o_sram_we_n;
    logic [15:0] o_sram_wdata;
    logic        o_sram_dq_oe;
    logic [15:0] i_sram_rdata;
    logic [15:0] o_mix_data;
    logic        o_mix_valid;

    modport master (
        input  i_wr_req, i_wr_addr, i_wr_data, i_sram_rdata,
        output o_wr_ack, o_sram_addr, o_sram_we_n, o_sram_wdata, o_sram_dq_oe,
        output o_mix_data, o_mix_valid
    );

    modport slave (
        output i_wr_req, i_wr_addr, i_wr_data, i_sram_rdata,
        input  o_wr_ack, o_sram_addr, o_sram_we_n, o_sram_wdata, o_sram_dq_oe,
        input  o_mix_data, o_mix_valid
    );
endinterface

// File: rtl/sram_mix_scheduler.sv
// Per-LRCK-frame SRAM track reader and saturating mixer, with recorder writes slotted between frames.
module sram_mix_scheduler #(
    parameter int          NUM_TRACK    = 4,
    parameter logic [19:0] TRACK_BASE   = 20'h20000,
    parameter logic [19:0] TRACK_STRIDE = 20'h20000,
    parameter logic [19:0] TRACK_LEN    = 20'h20000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_loop,
    input  logic [NUM_TRACK-1:0] i_track_en,
    input  logic                 i_daclrck,
    sram_mix_scheduler_if.master bus,
    output logic [19:0]          o_offset,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2:0]           o_dbg_state
);
    localparam int CNT_W = $clog2(NUM_TRACK + 1);
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(NUM_TRACK);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_WRITE      = 3'd2,
        S_READ       = 3'd3,
        S_SAT        = 3'd4
    } state_t;

    state_t               state, nxt_state;
    logic                 sync1, sync2, sync3;
    logic                 frame_evt, frame_go, frame_pend, stop_pend;
    logic [CNT_W-1:0]     rd_cnt;
    logic                 last_rd, end_of_track, take;
    logic [NUM_TRACK-1:0] en_q;
    logic signed [17:0]   acc, term, sum;
    logic [15:0]          clamped, mix_data;
    logic                 mix_valid;
    logic [19:0]          rd_addr;

    // sync3 only delays the synchronized LRCK for rising-edge detection
    assign frame_evt    = sync2 & ~sync3;
    assign frame_go     = frame_evt | frame_pend;
    assign last_rd      = (rd_cnt == LAST_RD);
    assign end_of_track = (o_offset == TRACK_LEN - 20'd1);
    assign rd_addr      = TRACK_BASE + TRACK_STRIDE * 20'(rd_cnt) + o_offset;
    assign o_busy       = (state != S_IDLE);
    assign o_dbg_state  = state;
    assign bus.o_mix_data  = mix_data;
    assign bus.o_mix_valid = mix_valid;

    // Read cycle rd_cnt returns the sample addressed one cycle earlier, i.e. track rd_cnt-1
    always_comb begin
        take = 1'b0;
        for (int i = 0; i < NUM_TRACK; i++)
            if (rd_cnt == CNT_W'(i + 1)) take = en_q[i];
        term = take ? {{2{bus.i_sram_rdata[15]}}, bus.i_sram_rdata} : 18'sd0;
        sum  = acc + term;
        if (sum > 18'sd32767)       clamped = 16'h7FFF;
        else if (sum < -18'sd32768) clamped = 16'h8000;
        else                        clamped = sum[15:0];
    end

    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE:       if (i_start && !i_stop) nxt_state = S_WAIT_FRAME;
            S_WAIT_FRAME: begin
                if (i_stop)             nxt_state = S_IDLE;
                else if (frame_go)      nxt_state = S_READ;
                else if (bus.i_wr_req)  nxt_state = S_WRITE;
            end
            S_WRITE:      nxt_state = (stop_pend || i_stop) ? S_IDLE : S_WAIT_FRAME;
            S_READ:       if (last_rd) nxt_state = S_SAT;
            S_SAT: begin
                if (stop_pend || i_stop || (end_of_track && !i_loop)) nxt_state = S_IDLE;
                else                                                  nxt_state = S_WAIT_FRAME;
            end
            default:      nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_sram_addr  = 20'h0;
        bus.o_sram_we_n  = 1'b1;
        bus.o_sram_wdata = 16'h0;
        bus.o_sram_dq_oe = 1'b0;
        bus.o_wr_ack     = 1'b0;
        if (state == S_READ && !last_rd) begin
            bus.o_sram_addr = rd_addr;
        end else if (state == S_WRITE) begin
            bus.o_sram_addr  = bus.i_wr_addr;
            bus.o_sram_wdata = bus.i_wr_data;
            bus.o_sram_we_n  = 1'b0;
            bus.o_sram_dq_oe = 1'b1;
            bus.o_wr_ack     = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            frame_pend <= 1'b0;
            stop_pend  <= 1'b0;
            rd_cnt     <= '0;
            en_q       <= '0;
            acc        <= 18'sd0;
            mix_data   <= 16'h0;
            mix_valid  <= 1'b0;
            o_done     <= 1'b0;
            o_offset   <= 20'h0;
        end else begin
            state     <= nxt_state;
            sync1     <= i_daclrck;
            sync2     <= sync1;
            sync3     <= sync2;
            mix_valid <= 1'b0;
            o_done    <= 1'b0;

            // One event may wait while the bus is busy; later ones are dropped
            if (nxt_state == S_IDLE || state == S_IDLE || state == S_WAIT_FRAME) frame_pend <= 1'b0;
            else if (frame_evt)                                                  frame_pend <= 1'b1;

            if (nxt_state == S_IDLE)                        stop_pend <= 1'b0;
            else if (state != S_WAIT_FRAME && i_stop)       stop_pend <= 1'b1;

            if (state == S_WAIT_FRAME && frame_go) en_q <= i_track_en;

            rd_cnt <= (state == S_READ) ? rd_cnt + 1'b1 : '0;
            acc    <= (state == S_READ) ? sum : 18'sd0;

            if (state == S_READ && last_rd) begin
                mix_data  <= clamped;
                mix_valid <= 1'b1;
                o_done    <= end_of_track;
            end

            if (nxt_state == S_IDLE) o_offset <= 20'h0;
            else if (state == S_SAT) o_offset <= end_of_track ? 20'h0 : o_offset + 20'd1;
        end
    end
endmodule

// File: tb/tb_sram_mix_scheduler.sv
// Directed bench for sram_mix_scheduler: mixing, saturation, write arbitration, stop, reset and end-of-track.
module tb_sram_mix_scheduler;
    logic        clk = 1'b0;
    logic        rst_n, start, stop, loop_en, lrck;
    logic        start2, stop2, loop2, lrck2;
    logic [3:0]  track_en;
    logic [19:0] offset, offset2;
    logic        busy, done, busy2, done2;
    logic [2:0]  dbg_state, dbg_state2;

    int total = 0;
    int bad = 0;
    int wr_cycles = 0;
    int valid_cnt = 0;
    logic [19:0] addr_log[$];
    logic [19:0] exp_q[$];
    logic [15:0] mem [logic [19:0]];

    sram_mix_scheduler_if bus1();
    sram_mix_scheduler_if bus2();

    sram_mix_scheduler dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_loop(loop_en),
        .i_track_en(track_en), .i_daclrck(lrck), .bus(bus1),
        .o_offset(offset), .o_busy(busy), .o_done(done), .o_dbg_state(dbg_state)
    );

    sram_mix_scheduler #(.TRACK_LEN(20'd4)) dut_short (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_stop(stop2), .i_loop(loop2),
        .i_track_en(track_en), .i_daclrck(lrck2), .bus(bus2),
        .o_offset(offset2), .o_busy(busy2), .o_done(done2), .o_dbg_state(dbg_state2)
    );

    assign bus2.i_wr_req     = 1'b0;
    assign bus2.i_wr_addr    = 20'h0;
    assign bus2.i_wr_data    = 16'h0;
    assign bus2.i_sram_rdata = 16'h0;

    // clock / reset
    always #5 clk = ~clk;

    // SRAM model: read data appears one cycle after the address
    always @(posedge clk) begin
        if (bus1.o_sram_we_n === 1'b0) mem[bus1.o_sram_addr] = bus1.o_sram_wdata;
        bus1.i_sram_rdata <= mem.exists(bus1.o_sram_addr) ? mem[bus1.o_sram_addr] : 16'h0;
    end

    always @(negedge clk) begin
        if (bus1.o_sram_we_n === 1'b0) wr_cycles++;
        if (bus1.o_mix_valid === 1'b1) valid_cnt++;
        if (bus1.o_sram_we_n === 1'b1 && bus1.o_sram_addr != 20'h0) addr_log.push_back(bus1.o_sram_addr);
    end

    // driver tasks
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic run_frame(output logic [15:0] data, output int lat);
        lat = -1;
        data = 16'h0;
        @(negedge clk); lrck = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus1.o_mix_valid === 1'b1) begin
                data = bus1.o_mix_data;
                lat = c;
                break;
            end
        end
        lrck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame2(output int lat, output logic dn);
        lat = -1;
        dn = 1'b0;
        @(negedge clk); lrck2 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus2.o_mix_valid === 1'b1) begin
                lat = c;
                dn = done2;
                break;
            end
        end
        lrck2 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // test tasks
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus1.o_sram_addr !== 20'h0) begin bad++; $display("FAIL reset_addr: got %h want 00000", bus1.o_sram_addr); end
        total++; if (bus1.o_sram_we_n !== 1'b1) begin bad++; $display("FAIL reset_we_n: got %b want 1", bus1.o_sram_we_n); end
        total++; if (bus1.o_sram_dq_oe !== 1'b0) begin bad++; $display("FAIL reset_dq_oe: got %b want 0", bus1.o_sram_dq_oe); end
        total++; if (bus1.o_sram_wdata !== 16'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0000", bus1.o_sram_wdata); end
        total++; if (bus1.o_mix_data !== 16'h0) begin bad++; $display("FAIL reset_mix_data: got %h want 0000", bus1.o_mix_data); end
        total++; if (bus1.o_mix_valid !== 1'b0) begin bad++; $display("FAIL reset_mix_valid: got %b want 0", bus1.o_mix_valid); end
        total++; if (bus1.o_wr_ack !== 1'b0) begin bad++; $display("FAIL reset_wr_ack: got %b want 0", bus1.o_wr_ack); end
        total++; if (offset !== 20'h0) begin bad++; $display("FAIL reset_offset: got %h want 00000", offset); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_basic_mix();
        logic [15:0] data;
        int lat;
        mem[20'h20000] = 16'h1000;
        mem[20'h40000] = 16'h0200;
        mem[20'h60000] = 16'h1111;
        mem[20'h80000] = 16'h2222;
        track_en = 4'b0011;
        loop_en = 1'b1;
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        addr_log.delete();
        exp_q = '{20'h20000, 20'h40000, 20'h60000, 20'h80000};
        run_frame(data, lat);
        total++; if (data !== 16'h1200) begin bad++; $display("FAIL basic_mix: got %h want 1200", data); end
        total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency: got %0d want 8", lat); end
        total++; if (addr_log.size() !== 4) begin bad++; $display("FAIL basic_addr_count: got %0d want 4", addr_log.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= addr_log.size() || addr_log[i] !== exp_q[i]) begin
                bad++; $display("FAIL basic_addr%0d: got %h want %h", i, (i < addr_log.size()) ? addr_log[i] : 20'h0, exp_q[i]);
            end
        end
        total++; if (offset !== 20'h1) begin bad++; $display("FAIL basic_offset: got %h want 00001", offset); end
        repeat (3) @(negedge clk);
        total++; if (bus1.o_mix_data !== 16'h1200 || bus1.o_mix_valid !== 1'b0) begin
            bad++; $display("FAIL basic_hold: got %h/%b want 1200/0", bus1.o_mix_data, bus1.o_mix_valid);
        end
        pulse_start();
        total++; if (offset !== 20'h1 || busy !== 1'b1) begin bad++; $display("FAIL start_ignored: got %h/%b want 00001/1", offset, busy); end
    endtask

    task automatic test_saturation();
        logic [15:0] smp [3][4] = '{'{16'h7000, 16'h7000, 16'h7000, 16'h7000},
                                    '{16'h8000, 16'h8000, 16'h8000, 16'h8000},
                                    '{16'hFFFF, 16'h0003, 16'h7000, 16'h7000}};
        logic [3:0]  en_v [3]  = '{4'b1111, 4'b1111, 4'b0011};
        logic [15:0] exp_v [3] = '{16'h7FFF, 16'h8000, 16'h0002};
        logic [15:0] data;
        int lat;
        for (int v = 0; v < 3; v++) begin
            for (int k = 0; k < 4; k++) mem[20'(32'h20000 * (k + 1) + v + 1)] = smp[v][k];
            track_en = en_v[v];
            run_frame(data, lat);
            total++; if (data !== exp_v[v]) begin bad++; $display("FAIL sat_mix%0d: got %h want %h", v, data, exp_v[v]); end
            total++; if (offset !== 20'(v + 2)) begin bad++; $display("FAIL sat_offset%0d: got %h want %h", v, offset, 20'(v + 2)); end
        end
        pulse_stop();
        total++; if (busy !== 1'b0 || offset !== 20'h0) begin bad++; $display("FAIL stop_wait: got %b/%h want 0/00000", busy, offset); end
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_stop_idle: got %b want 0", busy); end
    endtask

    task automatic test_write_priority();
        int vc = -1;
        int ack_c = -1;
        int w0;
        logic [19:0] ack_addr = 20'h0;
        logic [15:0] ack_wdata = 16'h0;
        logic [15:0] vdata = 16'h0;
        logic ack_oe = 1'b0;
        track_en = 4'b0011;
        pulse_start();
        w0 = wr_cycles;
        @(negedge clk); lrck = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 2) begin
                bus1.i_wr_req = 1'b1; bus1.i_wr_addr = 20'h00010; bus1.i_wr_data = 16'hABCD;
            end
            if (bus1.o_mix_valid === 1'b1 && vc < 0) begin vc = c; vdata = bus1.o_mix_data; end
            if (bus1.o_wr_ack === 1'b1 && ack_c < 0) begin
                ack_c = c; ack_addr = bus1.o_sram_addr; ack_wdata = bus1.o_sram_wdata;
                ack_oe = bus1.o_sram_dq_oe && !bus1.o_sram_we_n;
                bus1.i_wr_req = 1'b0;
            end
        end
        bus1.i_wr_req = 1'b0;
        lrck = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (vc !== 8) begin bad++; $display("FAIL wr_frame_first: got valid at %0d want 8", vc); end
        total++; if (vdata !== 16'h1200) begin bad++; $display("FAIL wr_frame_data: got %h want 1200", vdata); end
        total++; if (ack_c !== 10) begin bad++; $display("FAIL wr_ack_cycle: got %0d want 10", ack_c); end
        total++; if (ack_addr !== 20'h00010 || ack_wdata !== 16'hABCD) begin
            bad++; $display("FAIL wr_bus: got %h/%h want 00010/abcd", ack_addr, ack_wdata);
        end
        total++; if (ack_oe !== 1'b1) begin bad++; $display("FAIL wr_strobe: got %b want 1", ack_oe); end
        total++; if (wr_cycles - w0 !== 1) begin bad++; $display("FAIL wr_count: got %0d want 1", wr_cycles - w0); end
        total++; if (!mem.exists(20'h00010) || mem[20'h00010] !== 16'hABCD) begin
            bad++; $display("FAIL wr_mem: got %h want abcd", mem.exists(20'h00010) ? mem[20'h00010] : 16'h0);
        end
        pulse_stop();
    endtask

    task automatic test_stop_mid_read();
        int vc = -1;
        logic [15:0] vdata = 16'h0;
        logic b9 = 1'b1;
        logic [19:0] o9 = 20'hFFFFF;
        pulse_start();
        @(negedge clk); lrck = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 5) stop = 1'b1;
            if (c == 6) stop = 1'b0;
            if (bus1.o_mix_valid === 1'b1 && vc < 0) begin vc = c; vdata = bus1.o_mix_data; end
            if (c == 9) begin b9 = busy; o9 = offset; end
        end
        lrck = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (vc !== 8 || vdata !== 16'h1200) begin bad++; $display("FAIL stop_read_valid: got %0d/%h want 8/1200", vc, vdata); end
        total++; if (b9 !== 1'b0 || o9 !== 20'h0) begin bad++; $display("FAIL stop_read_idle: got %b/%h want 0/00000", b9, o9); end
    endtask

    task automatic test_track_len();
        int exp_off0 [4] = '{1, 2, 3, 0};
        logic exp_bsy0 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int exp_off1 [5] = '{1, 2, 3, 0, 1};
        int lat;
        logic dn;
        loop2 = 1'b0;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int f = 0; f < 4; f++) begin
            frame2(lat, dn);
            total++; if (lat !== 8) begin bad++; $display("FAIL len_latency%0d: got %0d want 8", f, lat); end
            total++; if (offset2 !== 20'(exp_off0[f])) begin bad++; $display("FAIL len_offset%0d: got %h want %0d", f, offset2, exp_off0[f]); end
            total++; if (dn !== (f == 3)) begin bad++; $display("FAIL len_done%0d: got %b want %b", f, dn, f == 3); end
            total++; if (busy2 !== exp_bsy0[f]) begin bad++; $display("FAIL len_busy%0d: got %b want %b", f, busy2, exp_bsy0[f]); end
        end
        loop2 = 1'b1;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int f = 0; f < 5; f++) begin
            frame2(lat, dn);
            total++; if (offset2 !== 20'(exp_off1[f])) begin bad++; $display("FAIL loop_offset%0d: got %h want %0d", f, offset2, exp_off1[f]); end
            total++; if (dn !== (f == 3)) begin bad++; $display("FAIL loop_done%0d: got %b want %b", f, dn, f == 3); end
            total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL loop_busy%0d: got %b want 1", f, busy2); end
        end
        @(negedge clk); stop2 = 1'b1;
        @(negedge clk); stop2 = 1'b0;
        total++; if (dbg_state2 !== 3'd0 || offset2 !== 20'h0) begin bad++; $display("FAIL loop_stop: got %0d/%h want 0/00000", dbg_state2, offset2); end
    endtask

    task automatic test_reset_mid_read();
        int v0;
        pulse_start();
        @(negedge clk); lrck = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (bus1.o_sram_addr !== 20'h60000 || dbg_state !== 3'd3) begin
            bad++; $display("FAIL rst_pre_addr: got %h/%0d want 60000/3", bus1.o_sram_addr, dbg_state);
        end
        rst_n = 1'b0;
        #1;
        total++; if (bus1.o_sram_addr !== 20'h0 || bus1.o_sram_we_n !== 1'b1 || bus1.o_sram_dq_oe !== 1'b0) begin
            bad++; $display("FAIL rst_mid_sram: got %h/%b/%b want 00000/1/0", bus1.o_sram_addr, bus1.o_sram_we_n, bus1.o_sram_dq_oe);
        end
        total++; if (bus1.o_mix_data !== 16'h0 || bus1.o_mix_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_mix: got %h/%b want 0000/0", bus1.o_mix_data, bus1.o_mix_valid);
        end
        total++; if (busy !== 1'b0 || offset !== 20'h0 || done !== 1'b0 || dbg_state !== 3'd0) begin
            bad++; $display("FAIL rst_mid_ctrl: got %b/%h/%b/%0d want 0/00000/0/0", busy, offset, done, dbg_state);
        end
        @(negedge clk); rst_n = 1'b1; lrck = 1'b0;
        v0 = valid_cnt;
        repeat (3) @(negedge clk);
        lrck = 1'b1;
        repeat (12) @(negedge clk);
        lrck = 1'b0;
        total++; if (valid_cnt - v0 !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_no_valid: got %0d/%b want 0/0", valid_cnt - v0, busy);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; lrck = 1'b0; track_en = 4'b0;
        start2 = 1'b0; stop2 = 1'b0; loop2 = 1'b0; lrck2 = 1'b0;
        bus1.i_wr_req = 1'b0; bus1.i_wr_addr = 20'h0; bus1.i_wr_data = 16'h0;
        test_reset();
        test_basic_mix();
        test_saturation();
        test_write_priority();
        test_stop_mid_read();
        test_track_len();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
